// File: rtl/hd_tdm_demux2.sv
// Receive side of the inverting 2:1 TDM mux chain: recovers two interleaved lanes into
// WIDTH-bit words, tracks SYNC-based frame alignment and counts alignment errors.
module hd_tdm_demux2 #(
  parameter int unsigned WIDTH  = 4,
  parameter bit          INVERT = 1'b1,
  parameter int unsigned ECW    = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIN,
  input  logic             SYNC,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic             VLD,
  output logic             LOCK,
  output logic             ERR,
  output logic [ECW-1:0]   ERRCNT
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LastIdx = BW'(WIDTH - 1);

  typedef enum logic [0:0] {StHunt, StLock} state_e;

  state_e           r_state, w_state_d;
  logic             r_slot, w_slot_d;
  logic [BW-1:0]    r_bitidx, w_bitidx_d;
  logic [WIDTH-1:0] r_sh0, w_sh0_d;
  logic [WIDTH-1:0] r_sh1, w_sh1_d;
  logic             r_pend, w_pend_d;
  logic [WIDTH-1:0] r_q0, w_q0_d;
  logic [WIDTH-1:0] r_q1, w_q1_d;
  logic             r_vld, w_vld_d;
  logic             r_err, w_err_d;
  logic [ECW-1:0]   r_errcnt, w_errcnt_d;

  logic w_d;
  logic w_at_start;
  logic w_last;

  assign w_d        = DIN ^ INVERT;
  assign w_at_start = !r_slot && (r_bitidx == '0);
  assign w_last     = r_slot && (r_bitidx == LastIdx);

  always_comb begin
    w_state_d  = r_state;
    w_slot_d   = r_slot;
    w_bitidx_d = r_bitidx;
    w_sh0_d    = r_sh0;
    w_sh1_d    = r_sh1;
    w_pend_d   = 1'b0;
    w_q0_d     = r_q0;
    w_q1_d     = r_q1;
    w_vld_d    = 1'b0;
    w_err_d    = 1'b0;

    // A frame completed on the previous edge publishes now, independent of EN.
    if (r_pend) begin
      w_q0_d  = r_sh0;
      w_q1_d  = r_sh1;
      w_vld_d = 1'b1;
    end

    if (EN) begin
      unique case (r_state)
        StHunt: begin
          if (SYNC) begin
            w_sh0_d[0] = w_d;
            w_slot_d   = 1'b1;
            w_bitidx_d = '0;
            w_state_d  = StLock;
          end
        end
        StLock: begin
          if (w_at_start && !SYNC) begin
            w_err_d   = 1'b1;
            w_state_d = StHunt;
          end else if (!w_at_start && SYNC) begin
            // Misplaced marker: drop the partial frame and restart on this sample.
            w_err_d    = 1'b1;
            w_sh0_d[0] = w_d;
            w_slot_d   = 1'b1;
            w_bitidx_d = '0;
          end else if (!r_slot) begin
            w_sh0_d[r_bitidx] = w_d;
            w_slot_d          = 1'b1;
          end else begin
            w_sh1_d[r_bitidx] = w_d;
            w_slot_d          = 1'b0;
            if (w_last) begin
              w_bitidx_d = '0;
              w_pend_d   = 1'b1;
            end else begin
              w_bitidx_d = r_bitidx + 1'b1;
            end
          end
        end
        default: begin
          w_state_d = StHunt;
        end
      endcase
    end
  end

  always_comb begin
    w_errcnt_d = r_errcnt;
    if (w_err_d && (r_errcnt != '1)) begin
      w_errcnt_d = r_errcnt + ECW'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state  <= StHunt;
      r_slot   <= 1'b0;
      r_bitidx <= '0;
      r_sh0    <= '0;
      r_sh1    <= '0;
      r_pend   <= 1'b0;
      r_q0     <= '0;
      r_q1     <= '0;
      r_vld    <= 1'b0;
      r_err    <= 1'b0;
      r_errcnt <= '0;
    end else begin
      r_state  <= w_state_d;
      r_slot   <= w_slot_d;
      r_bitidx <= w_bitidx_d;
      r_sh0    <= w_sh0_d;
      r_sh1    <= w_sh1_d;
      r_pend   <= w_pend_d;
      r_q0     <= w_q0_d;
      r_q1     <= w_q1_d;
      r_vld    <= w_vld_d;
      r_err    <= w_err_d;
      r_errcnt <= w_errcnt_d;
    end
  end

  assign Q0     = r_q0;
  assign Q1     = r_q1;
  assign VLD    = r_vld;
  assign LOCK   = (r_state == StLock);
  assign ERR    = r_err;
  assign ERRCNT = r_errcnt;

endmodule

// File: tb/tb_hd_tdm_demux2.sv
// Scoreboard bench for hd_tdm_demux2: stimulus queues expected words / error counts,
// monitors pop and compare whenever VLD or ERR pulses.
module tb_hd_tdm_demux2;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  // Instance A: WIDTH=4, INVERT=1, ECW=8
  logic       RST, EN, DIN, SYNC;
  logic [3:0] Q0, Q1;
  logic       VLD, LOCK, ERR;
  logic [7:0] ERRCNT;

  // Instance B: WIDTH=4, INVERT=0, ECW=2
  logic       b_rst, b_en, b_din, b_sync;
  logic [3:0] b_q0, b_q1;
  logic       b_vld, b_lock, b_err;
  logic [1:0] b_errcnt;

  hd_tdm_demux2 #(.WIDTH(4), .INVERT(1'b1), .ECW(8)) dut_a (
    .CK(CK), .RST(RST), .EN(EN), .DIN(DIN), .SYNC(SYNC),
    .Q0(Q0), .Q1(Q1), .VLD(VLD), .LOCK(LOCK), .ERR(ERR), .ERRCNT(ERRCNT)
  );

  hd_tdm_demux2 #(.WIDTH(4), .INVERT(1'b0), .ECW(2)) dut_b (
    .CK(CK), .RST(b_rst), .EN(b_en), .DIN(b_din), .SYNC(b_sync),
    .Q0(b_q0), .Q1(b_q1), .VLD(b_vld), .LOCK(b_lock), .ERR(b_err), .ERRCNT(b_errcnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] a_vq[$];
  logic [7:0] a_eq[$];
  logic [7:0] b_vq[$];
  logic [7:0] b_eq[$];
  time        a_vt[$];
  time        a_et[$];
  logic [7:0] a_ve, a_ee, b_ve, b_ee;
  time        t_first;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CK) begin
    if (VLD === 1'b1) begin
      a_vt.push_back($time);
      check("a_vld_expected", 64'(a_vq.size() != 0), 64'd1);
      if (a_vq.size() != 0) begin
        a_ve = a_vq.pop_front();
        check("a_q0q1", {Q0, Q1}, a_ve);
      end
    end
    if (ERR === 1'b1) begin
      a_et.push_back($time);
      check("a_err_expected", 64'(a_eq.size() != 0), 64'd1);
      if (a_eq.size() != 0) begin
        a_ee = a_eq.pop_front();
        check("a_errcnt", ERRCNT, a_ee);
      end
    end
    if (b_vld === 1'b1) begin
      check("b_vld_expected", 64'(b_vq.size() != 0), 64'd1);
      if (b_vq.size() != 0) begin
        b_ve = b_vq.pop_front();
        check("b_q0q1", {b_q0, b_q1}, b_ve);
      end
    end
    if (b_err === 1'b1) begin
      check("b_err_expected", 64'(b_eq.size() != 0), 64'd1);
      if (b_eq.size() != 0) begin
        b_ee = b_eq.pop_front();
        check("b_errcnt", b_errcnt, b_ee);
      end
    end
  end

  task automatic a_smp(input logic din, input logic sync);
    EN = 1'b1; DIN = din; SYNC = sync;
    @(posedge CK);
    #1;
  endtask

  task automatic a_idle(input int n);
    EN = 1'b0; SYNC = 1'b0;
    repeat (n) @(posedge CK);
    #1;
  endtask

  // Transmit-side model: lane words sent LSB first, lane 0 in even slots, inverted line.
  task automatic a_frame(input logic [3:0] q0, input logic [3:0] q1, input int gap);
    for (int i = 0; i < 4; i++) begin
      a_smp(~q0[i], i == 0);
      if (i == 0) t_first = $time - 1;
      if (i == 1 && gap > 0) a_idle(gap);
      a_smp(~q1[i], 1'b0);
    end
  endtask

  task automatic b_smp(input logic din, input logic sync);
    b_en = 1'b1; b_din = din; b_sync = sync;
    @(posedge CK);
    #1;
  endtask

  logic din_a[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic din_b[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  time  t_f1, t_f2, t_g;

  initial begin
    // Reset with EN/SYNC high to show reset priority.
    RST = 1'b1; EN = 1'b1; DIN = 1'b1; SYNC = 1'b1;
    b_rst = 1'b1; b_en = 1'b0; b_din = 1'b0; b_sync = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    check("rst_q0", Q0, 4'h0);
    check("rst_q1", Q1, 4'h0);
    check("rst_vld", VLD, 1'b0);
    check("rst_lock", LOCK, 1'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_errcnt", ERRCNT, 8'd0);
    check("b_rst_errcnt", b_errcnt, 2'd0);
    RST = 1'b0; b_rst = 1'b0;
    a_idle(2);

    // Clean frame from the literal line vector.
    a_vq.push_back({4'hA, 4'h3});
    for (int i = 0; i < 8; i++) begin
      a_smp(din_a[i], i == 0);
      if (i == 0) t_f1 = $time - 1;
    end
    check("f1_lock", LOCK, 1'b1);

    // Back-to-back frame.
    a_vq.push_back({4'h5, 4'hC});
    a_frame(4'h5, 4'hC, 0);
    t_f2 = t_first;
    check("f2_errcnt", ERRCNT, 8'd0);

    // Misplaced SYNC on the 5th sample.
    a_smp(1'b0, 1'b1);
    a_smp(1'b1, 1'b0);
    a_smp(1'b0, 1'b0);
    a_smp(1'b1, 1'b0);
    check("mis_q0_held", Q0, 4'h5);
    check("mis_q1_held", Q1, 4'hC);
    a_eq.push_back(8'd1);
    a_vq.push_back({4'h9, 4'h6});
    a_frame(4'h9, 4'h6, 0);
    check("mis_q0_no_vld", Q0, 4'h5);
    check("mis_errcnt", ERRCNT, 8'd1);
    check("f1_vld_time", a_vt[0], t_f1 + 85);
    check("f2_vld_time", a_vt[1], t_f2 + 85);
    check("vld_spacing", a_vt[1] - a_vt[0], 64'd80);

    // Missing SYNC at frame boundary: pending VLD still fires alongside ERR.
    a_eq.push_back(8'd2);
    a_smp(1'b1, 1'b0);
    check("miss_lock", LOCK, 1'b0);
    for (int i = 0; i < 5; i++) a_smp(1'(i & 1), 1'b0);
    check("miss_lock_hold", LOCK, 1'b0);
    check("miss_q0", Q0, 4'h9);
    check("miss_q1", Q1, 4'h6);
    check("miss_errcnt", ERRCNT, 8'd2);
    check("miss_vld_err_same", a_et[1], a_vt[2]);

    // EN gap of 3 cycles mid-frame.
    a_vq.push_back({4'hA, 4'h3});
    a_frame(4'hA, 4'h3, 3);
    t_g = t_first;

    // Reset mid-frame; the gap frame's VLD fires on the first sample here.
    a_smp(1'b0, 1'b1);
    a_smp(1'b1, 1'b0);
    a_smp(1'b1, 1'b0);
    check("gap_vld_time", a_vt[3], t_g + 85 + 30);
    RST = 1'b1; EN = 1'b0;
    @(posedge CK);
    #1;
    check("mrst_q0", Q0, 4'h0);
    check("mrst_q1", Q1, 4'h0);
    check("mrst_vld", VLD, 1'b0);
    check("mrst_lock", LOCK, 1'b0);
    check("mrst_err", ERR, 1'b0);
    check("mrst_errcnt", ERRCNT, 8'd0);
    RST = 1'b0;
    a_idle(12);

    // Instance B: non-inverting line, then ECW=2 saturation.
    b_vq.push_back({4'hA, 4'h3});
    for (int i = 0; i < 8; i++) b_smp(din_b[i], i == 0);
    b_smp(1'b0, 1'b1);
    b_eq.push_back(8'd1);
    b_eq.push_back(8'd2);
    b_eq.push_back(8'd3);
    b_eq.push_back(8'd3);
    b_eq.push_back(8'd3);
    for (int i = 0; i < 5; i++) b_smp(1'b0, 1'b1);
    b_en = 1'b0; b_sync = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    check("b_sat_errcnt", b_errcnt, 2'd3);
    check("b_lock", b_lock, 1'b1);
    check("b_q0", b_q0, 4'hA);
    check("b_q1", b_q1, 4'h3);

    check("a_vq_drained", a_vq.size(), 0);
    check("a_eq_drained", a_eq.size(), 0);
    check("b_vq_drained", b_vq.size(), 0);
    check("b_eq_drained", b_eq.size(), 0);
    check("a_vld_count", a_vt.size(), 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
